// File: rtl/mmio_console.sv
// Memory-mapped console and end-of-test status sink for a core's store port.
// Console stores feed a show-ahead character FIFO; a status store latches the test verdict.
module mmio_console #(
  parameter logic [31:0] CONSOLE_ADDR = 32'd65532,
  parameter logic [31:0] STATUS_ADDR  = 32'd65528,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CHAR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       dataadr,
  input  logic [31:0]       writedata,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_data,
  input  logic              char_ready,
  output logic              full,
  output logic [15:0]       drop_count,
  output logic              sim_done,
  output logic              sim_pass,
  output logic [30:0]       status_code
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StRunning, StPassed, StFailed} state_e;

  logic [CHAR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [15:0]       drop_q;
  state_e            state_q, state_d;
  logic [30:0]       code_q, code_d;

  logic console_hit, status_hit, pop, push, drop;

  // The console decode wins when both addresses coincide, so the FSM never sees such a store.
  assign console_hit = memwrite && (dataadr == CONSOLE_ADDR);
  assign status_hit  = memwrite && (dataadr == STATUS_ADDR) && !console_hit;

  assign char_valid = (count_q != '0);
  assign full       = (count_q == DepthCnt);
  assign pop        = char_valid && char_ready;
  assign push       = console_hit && (!full || pop);
  assign drop       = console_hit && full && !pop;
  assign char_data  = mem[rd_ptr_q];
  assign drop_count = drop_q;

  // Storage is deliberately left out of reset; char_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= writedata[CHAR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW+1)'(1);
      end
      if (drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if ((state_q == StRunning) && status_hit) begin
      state_d = (writedata == 32'd1) ? StPassed : StFailed;
      code_d  = writedata[31:1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRunning;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign sim_done    = (state_q != StRunning);
  assign sim_pass    = (state_q == StPassed);
  assign status_code = code_q;

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console: scenario tasks plus a negedge scoreboard
// that predicts every dequeued character from the stores driven.
module tb_mmio_console;

  localparam logic [31:0] CONS  = 32'd65532;
  localparam logic [31:0] STAT  = 32'd65528;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        full;
  logic [15:0] drop_count;
  logic        sim_done;
  logic        sim_pass;
  logic [30:0] status_code;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int         m_occ = 0;

  mmio_console dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .full       (full),
    .drop_count (drop_count),
    .sim_done   (sim_done),
    .sim_pass   (sim_pass),
    .status_code(status_code)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs are stable mid-cycle, so this sees exactly what the next edge will act on.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      logic       m_pop;
      logic       m_push;
      logic [7:0] e;
      m_pop = (m_occ != 0) && char_ready;
      checks++;
      if (char_valid !== (m_occ != 0)) begin
        errors++;
        $display("FAIL sb_valid: got %0b want %0b", char_valid, (m_occ != 0));
      end
      if (m_pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: unexpected character %0h", char_data);
        end else begin
          e = exp_q.pop_front();
          if (char_data !== e) begin
            errors++;
            $display("FAIL sb_data: got %0h want %0h", char_data, e);
          end
        end
      end
      m_push = memwrite && (dataadr == CONS) && ((m_occ < DEPTH) || m_pop);
      if (m_push) exp_q.push_back(writedata[7:0]);
      m_occ = m_occ + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] data);
    memwrite  = 1'b1;
    dataadr   = adr;
    writedata = data;
    cyc();
    memwrite  = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_occ = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic drain(input string name);
    int n = 0;
    char_ready = 1'b1;
    while (char_valid === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (char_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: valid=%0b left=%0d want valid=0 left=0", name, char_valid,
               exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memwrite = 1'b0;
    dataadr = '0;
    writedata = '0;
    char_ready = 1'b0;
    #1;
    checks += 6;
    if (char_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", char_valid); end
    if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b want 0", full); end
    if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0h want 0", drop_count); end
    if (sim_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", sim_done); end
    if (sim_pass !== 1'b0) begin errors++; $display("FAIL rst_pass: got %0b want 0", sim_pass); end
    if (status_code !== 31'd0) begin errors++; $display("FAIL rst_code: got %0h want 0", status_code); end
    do_reset();
  endtask

  task automatic test_hi();
    char_ready = 1'b1;
    // Near-miss addresses differ only above bit 15.
    store(CONS | 32'h0001_0000, 32'h58);
    store(STAT | 32'h0001_0000, 32'h1);
    checks += 2;
    if (char_valid !== 1'b0) begin errors++; $display("FAIL decode_cons: got %0b want 0", char_valid); end
    if (sim_done !== 1'b0) begin errors++; $display("FAIL decode_stat: got %0b want 0", sim_done); end
    memwrite = 1'b1; dataadr = CONS; writedata = 32'h48;
    #1;
    checks++;
    if (char_valid !== 1'b0) begin errors++; $display("FAIL no_bypass: got %0b want 0", char_valid); end
    cyc();
    checks += 2;
    if (char_valid !== 1'b1) begin errors++; $display("FAIL hi_valid_h: got %0b want 1", char_valid); end
    if (char_data !== 8'h48) begin errors++; $display("FAIL hi_data_h: got %0h want 48", char_data); end
    store(CONS, 32'h69);
    checks += 2;
    if (char_valid !== 1'b1) begin errors++; $display("FAIL hi_valid_i: got %0b want 1", char_valid); end
    if (char_data !== 8'h69) begin errors++; $display("FAIL hi_data_i: got %0h want 69", char_data); end
    cyc();
    checks++;
    if (char_valid !== 1'b0) begin errors++; $display("FAIL hi_empty: got %0b want 0", char_valid); end
  endtask

  task automatic test_fill_drop();
    char_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      store(CONS, 32'h41 + i);
      if (i == 14) begin
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL full_15: got %0b want 0", full); end
      end
      if (i == 15) begin
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_16: got %0b want 1", full); end
      end
    end
    checks += 2;
    if (drop_count !== 16'd2) begin errors++; $display("FAIL drop_2: got %0d want 2", drop_count); end
    if (char_data !== 8'h41) begin errors++; $display("FAIL fill_head: got %0h want 41", char_data); end
  endtask

  task automatic test_full_push_pop();
    char_ready = 1'b1;
    store(CONS, 32'h7A);
    checks += 2;
    if (full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %0b want 1", full); end
    if (drop_count !== 16'd2) begin errors++; $display("FAIL fpp_drop: got %0d want 2", drop_count); end
    drain("fpp");
  endtask

  task automatic test_status_pass();
    store(STAT, 32'd1);
    checks += 3;
    if (sim_done !== 1'b1) begin errors++; $display("FAIL pass_done: got %0b want 1", sim_done); end
    if (sim_pass !== 1'b1) begin errors++; $display("FAIL pass_pass: got %0b want 1", sim_pass); end
    if (status_code !== 31'd0) begin errors++; $display("FAIL pass_code: got %0h want 0", status_code); end
    store(STAT, 32'd7);
    checks += 3;
    if (sim_done !== 1'b1) begin errors++; $display("FAIL pass7_done: got %0b want 1", sim_done); end
    if (sim_pass !== 1'b1) begin errors++; $display("FAIL pass7_pass: got %0b want 1", sim_pass); end
    if (status_code !== 31'd0) begin errors++; $display("FAIL pass7_code: got %0h want 0", status_code); end
    char_ready = 1'b1;
    store(CONS, 32'h55);
    checks++;
    if (char_data !== 8'h55) begin errors++; $display("FAIL after_done: got %0h want 55", char_data); end
    drain("pass");
  endtask

  task automatic test_fail_and_reset();
    do_reset();
    char_ready = 1'b0;
    for (int i = 0; i < 19; i++) store(CONS, 32'h61 + i);
    char_ready = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    char_ready = 1'b0;
    checks += 3;
    if (drop_count !== 16'd3) begin errors++; $display("FAIL drop_3: got %0d want 3", drop_count); end
    if (full !== 1'b0) begin errors++; $display("FAIL part_full: got %0b want 0", full); end
    if (char_data !== 8'h6C) begin errors++; $display("FAIL part_head: got %0h want 6c", char_data); end
    store(STAT, 32'h0000_000B);
    store(32'd65524, 32'hFFFF_FFFF);
    store(STAT, 32'd1);
    checks += 5;
    if (sim_done !== 1'b1) begin errors++; $display("FAIL fail_done: got %0b want 1", sim_done); end
    if (sim_pass !== 1'b0) begin errors++; $display("FAIL fail_pass: got %0b want 0", sim_pass); end
    if (status_code !== 31'd5) begin errors++; $display("FAIL fail_code: got %0d want 5", status_code); end
    if (drop_count !== 16'd3) begin errors++; $display("FAIL other_drop: got %0d want 3", drop_count); end
    if (char_valid !== 1'b1) begin errors++; $display("FAIL other_valid: got %0b want 1", char_valid); end
    // Asynchronous pulse strictly between edges.
    #1 reset = 1'b1;
    clear_model();
    #1;
    checks += 6;
    if (char_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", char_valid); end
    if (full !== 1'b0) begin errors++; $display("FAIL mid_full: got %0b want 0", full); end
    if (drop_count !== 16'd0) begin errors++; $display("FAIL mid_drop: got %0d want 0", drop_count); end
    if (sim_done !== 1'b0) begin errors++; $display("FAIL mid_done: got %0b want 0", sim_done); end
    if (sim_pass !== 1'b0) begin errors++; $display("FAIL mid_pass: got %0b want 0", sim_pass); end
    if (status_code !== 31'd0) begin errors++; $display("FAIL mid_code: got %0h want 0", status_code); end
    reset = 1'b0;
    #1;
    store(CONS, 32'h31);
    store(CONS, 32'h32);
    checks++;
    if (char_data !== 8'h31) begin errors++; $display("FAIL post_rst_head: got %0h want 31", char_data); end
    drain("post_rst");
  endtask

  initial begin
    test_reset();
    test_hi();
    test_fill_drop();
    test_full_push_pop();
    test_status_pass();
    test_fail_and_reset();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
- REQ-001: Parameter CONSOLE_ADDR, default 32'd65532 (0xFFFC); store address treated as a console character write.
- REQ-002: Parameter STATUS_ADDR, default 32'd65528 (0xFFF8); store address treated as an end-of-test status write.
- REQ-003: Parameter DEPTH, default 16; character FIFO entries; power of two, >= 2.
- REQ-004: Parameter CHAR_W, default 8; character width, 1..32.
- REQ-005: clk  input  1  single clock; all state updates on rising edge.
- REQ-006: reset  input  1  asynchronous, active-high reset.
- REQ-007: memwrite  input  1  core store strobe, one store per asserted cycle.
- REQ-008: dataadr  input  32  store byte address.
- REQ-009: writedata  input  32  store data.
- REQ-010: char_valid  output  1  FIFO head holds a character.
- REQ-011: char_data  output  CHAR_W  FIFO head character.
- REQ-012: char_ready  input  1  sink accepts head this cycle.
- REQ-013: full  output  1  FIFO holds DEPTH entries.
- REQ-014: drop_count  output  16  characters lost to overflow, saturating.
- REQ-015: sim_done  output  1  status write received.
- REQ-016: sim_pass  output  1  status write value was 1.
- REQ-017: status_code  output  31  writedata[31:1] of the status write.

Function
- REQ-018: Address decode SHALL compare all 32 bits of dataadr; memwrite to any other address SHALL have no effect.
- REQ-019: Push: memwrite && dataadr==CONSOLE_ADDR && (!full || pop this cycle) SHALL enqueue writedata[CHAR_W-1:0].
- REQ-020: Pop: char_valid && char_ready SHALL dequeue the head at the rising edge.
- REQ-021: char_valid SHALL equal (occupancy != 0); char_data SHALL present the head with no extra pop latency (show-ahead).
- REQ-022: Push-to-char_valid latency SHALL be 1 cycle when empty; no bypass of an empty FIFO within the same cycle.
- REQ-023: Simultaneous push and pop SHALL leave occupancy unchanged, including when full (push accepted) and when occupancy is 1.
- REQ-024: Read/write pointers SHALL be log2(DEPTH) bits, wrapping DEPTH-1 -> 0; occupancy SHALL be a separate log2(DEPTH)+1-bit counter.
- REQ-025: Console push while full with no pop SHALL drop the character and increment drop_count, holding at 16'hFFFF.
- REQ-026: Status FSM states RUNNING, PASSED, FAILED; store to STATUS_ADDR in RUNNING SHALL go to PASSED if writedata==32'd1, else FAILED.
- REQ-027: In PASSED/FAILED, further status stores SHALL be ignored (first write wins); only reset SHALL return the FSM to RUNNING.
- REQ-028: sim_done = (state != RUNNING); sim_pass = (state == PASSED); status_code SHALL latch writedata[31:1] on the RUNNING transition.
- REQ-029: Console pushes and pops SHALL continue to operate after sim_done.
- REQ-030: If CONSOLE_ADDR == STATUS_ADDR, the console function SHALL take priority and the status FSM SHALL never leave RUNNING.

Reset
- REQ-031: reset high SHALL immediately, without a clock: empty FIFO, pointers 0, char_valid=0, full=0, drop_count=0, state RUNNING, sim_done=0, sim_pass=0, status_code=0.
- REQ-032: char_data SHALL be don't-care while char_valid=0; FIFO storage is not reset.
- REQ-033: Reset asserted mid-stream SHALL discard all queued characters; the first push after deassertion SHALL be dequeued first.

Verification
- REQ-034: Write 'H','i' (0x48, 0x69) to 65532, char_ready=1 -> char_data 0x48 then 0x69 on consecutive cycles, each 1 cycle after its store.
- REQ-035: char_ready=0, 18 stores of 0x41..0x52 with DEPTH=16 -> full=1 after 16th, drop_count=2; draining yields 0x41..0x50 in order.
- REQ-036: Full FIFO, store 0x7A with char_ready=1 same cycle -> full stays 1, drop_count unchanged, 0x7A emerges last.
- REQ-037: Store 1 to 65528 -> sim_done=1, sim_pass=1 next cycle; later store 7 to 65528 -> no change.
- REQ-038: Store 0x0000000B to 65528 -> sim_done=1, sim_pass=0, status_code=5; store to 65524 -> no output change.
- REQ-039: 5 queued characters, sim_done=1, drop_count=3, reset pulsed mid-cycle -> all outputs at reset values before the next clock edge.
